// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one read/write memory port between RV32I instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on contention; by default data always wins.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_write_mem,
  output logic [2:0]  m_funct3,
  output logic [31:0] m_write_address,
  output logic [31:0] m_write_data,
  output logic [31:0] m_read_address,
  input  logic [31:0] m_read_data,
  output logic [15:0] i_stall_cnt,
  output logic [15:0] d_stall_cnt
);

  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_I     = 2'd1,
    RSP_I_ERR = 2'd2,
    RSP_D     = 2'd3
  } rsp_t;

  rsp_t        r_rsp_sel;
  rsp_t        w_rsp_next;
  logic        r_last_d;
  logic [15:0] r_i_stall;
  logic [15:0] r_d_stall;
  logic        w_d_first;
  logic        w_i_mis;
  logic        w_i_gnt;
  logic        w_d_gnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_d_first = ~r_last_d;
`else
  assign w_d_first = 1'b1;
`endif

  // Grants are masked during reset so no transaction, in particular no write, reaches memory.
  assign w_d_gnt = rst_n & d_req & (~i_req | w_d_first);
  assign w_i_gnt = rst_n & i_req & ~w_d_gnt;
  assign w_i_mis = |i_addr[1:0];

  assign i_gnt = w_i_gnt;
  assign d_gnt = w_d_gnt;

  always_comb begin
    m_write_mem     = 1'b0;
    m_funct3        = 3'b010;
    m_write_address = 32'd0;
    m_write_data    = 32'd0;
    m_read_address  = 32'd0;
    if (w_i_gnt) begin
      if (!w_i_mis) m_read_address = i_addr;
    end else if (w_d_gnt) begin
      m_funct3 = d_funct3;
      if (d_we) begin
        m_write_mem     = 1'b1;
        m_write_address = d_addr;
        m_write_data    = d_wdata;
      end else begin
        m_read_address = d_addr;
      end
    end
  end

  always_comb begin
    w_rsp_next = RSP_NONE;
    if (w_i_gnt)                w_rsp_next = w_i_mis ? RSP_I_ERR : RSP_I;
    else if (w_d_gnt && !d_we)  w_rsp_next = RSP_D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_sel <= RSP_NONE;
      r_last_d  <= 1'b1;
      r_i_stall <= 16'd0;
      r_d_stall <= 16'd0;
    end else begin
      r_rsp_sel <= w_rsp_next;
      if (w_i_gnt || w_d_gnt) r_last_d <= w_d_gnt;
      if (i_req && !w_i_gnt && (r_i_stall != 16'hFFFF)) r_i_stall <= r_i_stall + 16'd1;
      if (d_req && !w_d_gnt && (r_d_stall != 16'hFFFF)) r_d_stall <= r_d_stall + 16'd1;
    end
  end

  // A misaligned fetch returns zero data regardless of what memory drives.
  assign i_rvalid    = (r_rsp_sel == RSP_I) || (r_rsp_sel == RSP_I_ERR);
  assign i_err       = (r_rsp_sel == RSP_I_ERR);
  assign i_rdata     = (r_rsp_sel == RSP_I) ? m_read_data : 32'd0;
  assign d_rvalid    = (r_rsp_sel == RSP_D);
  assign d_rdata     = (r_rsp_sel == RSP_D) ? m_read_data : 32'd0;
  assign i_stall_cnt = r_i_stall;
  assign d_stall_cnt = r_d_stall;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-addressed memory stand-in plus a per-cycle reference model of grants,
// routed responses and stall counters, with literal checks on the directed scenarios.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_funct3 = 3'b010;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [31:0] m_read_data = 32'd0;
  logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, m_write_mem;
  logic [31:0] i_rdata, d_rdata, m_write_address, m_write_data, m_read_address;
  logic [2:0]  m_funct3;
  logic [15:0] i_stall_cnt, d_stall_cnt;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_write_mem(m_write_mem), .m_funct3(m_funct3), .m_write_address(m_write_address),
    .m_write_data(m_write_data), .m_read_address(m_read_address), .m_read_data(m_read_data),
    .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory stand-in: byte array, one-cycle registered read, sign/zero extension by funct3.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f);
    logic [7:0] b0, b1, b2, b3;
    b0 = mb(a); b1 = mb(a + 32'd1); b2 = mb(a + 32'd2); b3 = mb(a + 32'd3);
    case (f)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (m_write_mem) begin
        mem[m_write_address] = m_write_data[7:0];
        if (m_funct3[1:0] != 2'b00) mem[m_write_address + 32'd1] = m_write_data[15:8];
        if (m_funct3[1:0] == 2'b10) begin
          mem[m_write_address + 32'd2] = m_write_data[23:16];
          mem[m_write_address + 32'd3] = m_write_data[31:24];
        end
      end
      m_read_data = mem_rd(m_read_address, m_funct3);
    end
  end

  // Reference model, checked on every falling edge.
  initial begin
    logic        gi, gd, e_wm, exp_iv, exp_ierr, exp_dv, md_last;
    logic [2:0]  e_f;
    logic [31:0] e_ra, e_wa, e_wd, exp_irdata, exp_drdata;
    int          mi_cnt, md_cnt;
    exp_iv = 0; exp_ierr = 0; exp_dv = 0; exp_irdata = 0; exp_drdata = 0;
    md_last = 1; mi_cnt = 0; md_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_i_gnt", 32'(i_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_m_write_mem", 32'(m_write_mem), 32'd0);
        chk("rst_m_funct3", 32'(m_funct3), 32'd2);
        chk("rst_i_stall", 32'(i_stall_cnt), 32'd0);
        chk("rst_d_stall", 32'(d_stall_cnt), 32'd0);
        exp_iv = 0; exp_ierr = 0; exp_dv = 0; exp_irdata = 0; exp_drdata = 0;
        md_last = 1; mi_cnt = 0; md_cnt = 0;
      end else begin
        chk("i_rvalid", 32'(i_rvalid), 32'(exp_iv));
        chk("i_err", 32'(i_err), 32'(exp_ierr));
        chk("i_rdata", i_rdata, exp_irdata);
        chk("d_rvalid", 32'(d_rvalid), 32'(exp_dv));
        chk("d_rdata", d_rdata, exp_drdata);
        chk("i_stall_cnt", 32'(i_stall_cnt), 32'(mi_cnt));
        chk("d_stall_cnt", 32'(d_stall_cnt), 32'(md_cnt));
        if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          gd = !md_last;
`else
          gd = 1'b1;
`endif
          gi = !gd;
        end else begin
          gi = i_req;
          gd = d_req;
        end
        e_wm = 0; e_f = 3'b010; e_ra = 0; e_wa = 0; e_wd = 0;
        if (gi) begin
          if (i_addr[1:0] == 2'b00) e_ra = i_addr;
        end else if (gd) begin
          e_f = d_funct3;
          if (d_we) begin e_wm = 1; e_wa = d_addr; e_wd = d_wdata; end
          else e_ra = d_addr;
        end
        chk("i_gnt", 32'(i_gnt), 32'(gi));
        chk("d_gnt", 32'(d_gnt), 32'(gd));
        chk("m_write_mem", 32'(m_write_mem), 32'(e_wm));
        chk("m_funct3", 32'(m_funct3), 32'(e_f));
        chk("m_read_address", m_read_address, e_ra);
        chk("m_write_address", m_write_address, e_wa);
        chk("m_write_data", m_write_data, e_wd);
        exp_iv     = gi;
        exp_ierr   = gi && (i_addr[1:0] != 2'b00);
        exp_irdata = (gi && !exp_ierr) ? mem_rd(i_addr, 3'b010) : 32'd0;
        exp_dv     = gd && !d_we;
        exp_drdata = exp_dv ? mem_rd(d_addr, d_funct3) : 32'd0;
        if (gi || gd) md_last = gd;
        if (i_req && !gi && mi_cnt < 65535) mi_cnt++;
        if (d_req && !gd && md_cnt < 65535) md_cnt++;
      end
    end
  end

  logic [31:0] g_ra;

  // Waits (bounded) for the grant, then drops the request at the start of the next cycle.
  task automatic wait_gnt(input bit is_d);
    int n = 0;
    @(negedge clk);
    while (!(is_d ? d_gnt : i_gnt) && n < 16) begin
      @(negedge clk);
      n++;
    end
    g_ra = m_read_address;
    chk(is_d ? "d_grant_wait" : "i_grant_wait", 32'(is_d ? d_gnt : i_gnt), 32'd1);
    @(posedge clk); #1;
    if (is_d) d_req = 0; else i_req = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    i_req = 1; i_addr = a;
    wait_gnt(0);
  endtask

  task automatic dacc(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1; d_we = we; d_funct3 = f; d_addr = a; d_wdata = wd;
    wait_gnt(1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; i_req = 0; d_req = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  logic cont_d [8];

  initial begin
    mem[32'h100] = 8'h93; mem[32'h101] = 8'h00; mem[32'h102] = 8'h50; mem[32'h103] = 8'h00;

    // Reset with both requesters active.
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200;
    @(negedge clk);
    chk("reset_i_gnt", 32'(i_gnt), 32'd0);
    chk("reset_d_gnt", 32'(d_gnt), 32'd0);
    chk("reset_m_funct3", 32'(m_funct3), 32'h2);
    chk("reset_i_stall", 32'(i_stall_cnt), 32'd0);
    @(posedge clk); #1;
    i_req = 0; d_req = 0; rst_n = 1;

    // Solo fetch.
    fetch(32'h100);
    @(negedge clk);
    chk("fetch_rvalid", 32'(i_rvalid), 32'd1);
    chk("fetch_rdata", i_rdata, 32'h00500093);
    chk("fetch_err", 32'(i_err), 32'd0);
    idle_cycle();

    // sb, then lbu and lb of the same byte.
    dacc(1'b1, 3'b000, 32'h203, 32'h123456AB);
    @(negedge clk);
    chk("store_no_rvalid", 32'(d_rvalid), 32'd0);
    idle_cycle();
    dacc(1'b0, 3'b100, 32'h203, 32'd0);
    @(negedge clk);
    chk("lbu_rdata", d_rdata, 32'h000000AB);
    idle_cycle();
    dacc(1'b0, 3'b000, 32'h203, 32'd0);
    @(negedge clk);
    chk("lb_rdata", d_rdata, 32'hFFFFFFAB);
    idle_cycle();

    // sh immediately followed by lhu of the same address.
    dacc(1'b1, 3'b001, 32'h210, 32'h0000BEEF);
    dacc(1'b0, 3'b101, 32'h210, 32'd0);
    @(negedge clk);
    chk("st_ld_fwd", d_rdata, 32'h0000BEEF);
    idle_cycle();

    // Misaligned fetch.
    fetch(32'h102);
    chk("misaligned_read_addr", g_ra, 32'd0);
    @(negedge clk);
    chk("misaligned_rvalid", 32'(i_rvalid), 32'd1);
    chk("misaligned_err", 32'(i_err), 32'd1);
    chk("misaligned_rdata", i_rdata, 32'd0);
    idle_cycle();

    // Eight cycles of contention from a fresh reset.
    do_reset();
    i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h200;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cont_d[k] = d_gnt;
      @(posedge clk); #1;
    end
    i_req = 0; d_req = 0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("contention_grant", 32'(cont_d[k]), 32'(k % 2));
`else
      chk("contention_grant", 32'(cont_d[k]), 32'd1);
`endif
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("contention_i_stall", 32'(i_stall_cnt), 32'd4);
    chk("contention_d_stall", 32'(d_stall_cnt), 32'd4);
`else
    chk("contention_i_stall", 32'(i_stall_cnt), 32'd8);
    chk("contention_d_stall", 32'(d_stall_cnt), 32'd0);
`endif
    idle_cycle();

    // Reset pulse while a load response is outstanding.
    dacc(1'b0, 3'b100, 32'h203, 32'd0);
    rst_n = 0;
    @(negedge clk);
    chk("rst_kill_rvalid", 32'(d_rvalid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_after_rvalid", 32'(d_rvalid), 32'd0);
    idle_cycle();

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Starve fetch past the counter range.
    do_reset();
    i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h200;
    repeat (70000) @(posedge clk);
    #1;
    i_req = 0; d_req = 0;
    @(negedge clk);
    chk("i_stall_saturated", 32'(i_stall_cnt), 32'h0000FFFF);
    idle_cycle();
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
